// File: rtl/nfc_cmd_sched.sv
// Round-robin command scheduler sharing one NAND flash controller between NREQ requesters.
// Each requester owns a small FIFO; one command is outstanding at a time, with a sticky watchdog.
module nfc_cmd_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [33*NREQ-1:0]        req_cmd,
  output logic [NREQ-1:0]           req_ready,
  output logic                      cpl_valid,
  output logic [$clog2(NREQ)-1:0]   cpl_id,
  output logic [32:0]               nfc_cmd,
  output logic                      nfc_cmd_valid,
  input  logic                      nfc_done,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CIW = IDW + 1;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [15:0]   TimeoutC = 16'(TIMEOUT);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_BUSY  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [32:0]    mem_q   [NREQ][DEPTH];
  logic [PW-1:0]  wptr_q  [NREQ];
  logic [PW-1:0]  rptr_q  [NREQ];
  logic [CW-1:0]  count_q [NREQ];
  logic [NREQ-1:0] push, pop;
  logic [IDW-1:0] last_q, tag_q, win, cpl_id_q;
  logic [CIW-1:0] cand;
  logic           win_found, issue;
  logic [15:0]    wdog_q;
  logic           cpl_q, err_q;
  logic [32:0]    cmd_q;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (count_q[i] != DepthC);
      push[i]      = req_valid[i] && req_ready[i];
    end
  end

  // Round-robin search starting just after the last grant.
  always_comb begin
    win       = last_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + CIW'(k);
      if (cand >= CIW'(NREQ)) cand = cand - CIW'(NREQ);
      if (!win_found && count_q[cand[IDW-1:0]] != '0) begin
        win_found = 1'b1;
        win       = cand[IDW-1:0];
      end
    end
  end

  // Hold off selection while the completion pulse is out, so a new issue lands at done+3.
  assign issue = (state_q == S_IDLE) && win_found && !cpl_q;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      pop[i] = issue && (win == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
        count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= req_cmd[33*i +: 33];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (nfc_done) state_d = S_IDLE;
      S_IDLE:  if (issue) state_d = S_ISSUE;
      S_ISSUE: state_d = S_BUSY;
      S_BUSY:  if (nfc_done) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      last_q   <= IDW'(NREQ - 1);
      tag_q    <= '0;
      cmd_q    <= '0;
      cpl_q    <= 1'b0;
      cpl_id_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cpl_q   <= 1'b0;
      if (issue) begin
        cmd_q  <= mem_q[win][rptr_q[win]];
        tag_q  <= win;
        last_q <= win;
      end
      if (state_q == S_ISSUE) begin
        wdog_q <= '0;
      end else if (state_q == S_BUSY && !nfc_done && wdog_q != TimeoutC) begin
        wdog_q <= wdog_q + 16'd1;
        if (wdog_q + 16'd1 == TimeoutC) err_q <= 1'b1;
      end
      if (state_q == S_BUSY && nfc_done) begin
        cpl_q    <= 1'b1;
        cpl_id_q <= tag_q;
      end
    end
  end

  assign cpl_valid     = cpl_q;
  assign cpl_id        = cpl_id_q;
  assign nfc_cmd       = cmd_q;
  assign nfc_cmd_valid = (state_q == S_ISSUE);
  assign busy          = (state_q == S_ISSUE) || (state_q == S_BUSY);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_nfc_cmd_sched.sv
// Scoreboard bench for nfc_cmd_sched: per-requester reference queues, round-robin winner
// prediction, completion-id queue, and timing bounds derived from cycle stamps.
module tb_nfc_cmd_sched;

  localparam int NREQ    = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [33*NREQ-1:0]      req_cmd = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    cpl_valid;
  logic [$clog2(NREQ)-1:0] cpl_id;
  logic [32:0]             nfc_cmd;
  logic                    nfc_cmd_valid;
  logic                    nfc_done = 1'b0;
  logic                    busy;
  logic                    err_timeout;

  always #5 clk = ~clk;

  nfc_cmd_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ready    (req_ready),
    .cpl_valid    (cpl_valid),
    .cpl_id       (cpl_id),
    .nfc_cmd      (nfc_cmd),
    .nfc_cmd_valid(nfc_cmd_valid),
    .nfc_done     (nfc_done),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // NFC responder: answers each issue after resp_dly cycles, or on request from the stimulus.
  int done_req = 0;
  int done_ack = 0;
  int resp_cnt = 0;
  int resp_dly = 5;
  bit resp_en  = 1'b1;

  always begin
    @(posedge clk);
    #2;
    nfc_done = 1'b0;
    if (done_ack != done_req) begin
      nfc_done = 1'b1;
      done_ack++;
    end else if (resp_cnt == 1) begin
      nfc_done = 1'b1;
      resp_cnt = 0;
    end else if (resp_cnt > 1) begin
      resp_cnt--;
    end
    if (nfc_cmd_valid && resp_en && !rst) resp_cnt = resp_dly;
  end

  // Reference model state
  logic [32:0]     mq  [NREQ][$];
  int              mst [NREQ][$];
  int              cplq[$];
  int              last_g, issue_c, init_c, cdone_c, cpl_due, idle_wait, w, j, e1, smin;
  bit              outst, init_done, err_exp, post_rst, found, pend;
  logic [32:0]     cmd_exp;
  logic [NREQ-1:0] rdy_exp;

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      mq[i].delete();
      mst[i].delete();
    end
    cplq.delete();
    last_g    = NREQ - 1;
    outst     = 1'b0;
    init_done = 1'b0;
    err_exp   = 1'b0;
    cmd_exp   = '0;
    issue_c   = -100;
    init_c    = -100;
    cdone_c   = -100;
    cpl_due   = -1;
    idle_wait = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      post_rst = 1'b1;
    end else begin
      if (post_rst) check("rst_cpl_id", 64'(cpl_id), 64'(0));
      post_rst = 1'b0;

      if (nfc_cmd_valid) begin
        check("issue_after_init", 64'(init_done), 64'(1));
        check("issue_while_busy", 64'(outst), 64'(0));
        smin  = 1 << 30;
        found = 1'b0;
        w     = 0;
        for (int i = 0; i < NREQ; i++)
          if (mq[i].size() > 0 && mst[i][0] < smin) smin = mst[i][0];
        for (int k = 1; k <= NREQ; k++) begin
          j = (last_g + k) % NREQ;
          if (!found && mq[j].size() > 0 && mst[j][0] <= cyc - 2) begin
            found = 1'b1;
            w     = j;
          end
        end
        check("issue_has_pending", 64'(found), 64'(1));
        e1 = (smin > init_c) ? smin + 2 : init_c + 2;
        if (e1 > cdone_c + 3) check("issue_latency", 64'(cyc), 64'(e1));
        else check("issue_gap", 64'(cyc >= cdone_c + 3), 64'(1));
        if (found) begin
          cmd_exp = mq[w].pop_front();
          void'(mst[w].pop_front());
          last_g = w;
          cplq.push_back(w);
        end
        outst   = 1'b1;
        issue_c = cyc;
      end
      check("nfc_cmd", 64'(nfc_cmd), 64'(cmd_exp));
      check("busy", 64'(busy), 64'(outst));

      if (outst && cyc >= issue_c + 1 + TIMEOUT) err_exp = 1'b1;
      check("err_timeout", 64'(err_timeout), 64'(err_exp));

      check("cpl_valid", 64'(cpl_valid), 64'(cyc == cpl_due));
      if (cyc == cpl_due && cplq.size() > 0) begin
        w = cplq.pop_front();
        check("cpl_id", 64'(cpl_id), 64'(w));
      end

      for (int i = 0; i < NREQ; i++) rdy_exp[i] = (mq[i].size() < DEPTH);
      check("req_ready", 64'(req_ready), 64'(rdy_exp));

      if (nfc_done) begin
        if (!init_done) begin
          init_done = 1'b1;
          init_c    = cyc;
        end else if (outst && cyc > issue_c) begin
          outst   = 1'b0;
          cpl_due = cyc + 1;
          cdone_c = cyc;
        end
      end

      pend = 1'b0;
      for (int i = 0; i < NREQ; i++) pend = pend | (mq[i].size() > 0);
      if (init_done && !outst && pend) idle_wait++;
      else idle_wait = 0;
      check("issue_stall", 64'(idle_wait > 6), 64'(0));

      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && rdy_exp[i]) begin
          mq[i].push_back(req_cmd[33*i +: 33]);
          mst[i].push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input int i, input logic [32:0] cmd);
    req_valid[i]         = 1'b1;
    req_cmd[33*i +: 33]  = cmd;
    tick();
    req_valid[i] = 1'b0;
  endtask

  initial begin
    // Init: command waits in the FIFO until the first nfc_done
    do_reset();
    tick();
    push(0, 33'h1_0000_0081);
    repeat (5) tick();
    done_req++;
    repeat (20) tick();

    // Round-robin from reset: two commands per requester
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]        = 1'b1;
        req_cmd[33*i +: 33] = 33'((r == 0 ? 32'h10 : 32'h20) + 32'(i));
      end
      tick();
    end
    req_valid = '0;
    tick();
    done_req++;
    repeat (90) tick();

    // FIFO full on requester 2 while the NFC is slow
    resp_dly = 30;
    push(0, 33'h0_0000_0abc);
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      req_valid[2]     = 1'b1;
      req_cmd[66 +: 33] = 33'(32'h200 + 32'(k));
      tick();
    end
    req_valid = '0;
    repeat (220) tick();
    resp_dly = 5;

    // Idle NFC
    repeat (20) tick();

    // Watchdog: withhold nfc_done past TIMEOUT, then complete late
    resp_en = 1'b0;
    push(1, 33'h1_2345_6789);
    repeat (TIMEOUT + 15) tick();
    done_req++;
    repeat (15) tick();

    // Reset mid-command with three queued commands
    push(3, 33'h0_dead_beef);
    repeat (5) tick();
    req_valid                = 4'b1011;
    req_cmd[0 +: 33]         = 33'h0_0000_0001;
    req_cmd[33 +: 33]        = 33'h0_0000_0002;
    req_cmd[99 +: 33]        = 33'h0_0000_0003;
    tick();
    req_valid = '0;
    tick();
    do_reset();
    repeat (3) tick();
    done_req++;
    repeat (15) tick();
    resp_en = 1'b1;

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        repeat (2) tick();
        done_req++;
      end
      resp_dly = $urandom_range(1, 8);
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]        = ($urandom_range(0, 99) < 3);
        req_cmd[33*i +: 33] = {1'($urandom_range(0, 1)), $urandom};
      end
      tick();
    end
    req_valid = '0;
    repeat (150) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
